serial_adder: RTL and testbench



---
 rtl/serial_adder.sv | 152 +++++++++++++++
 tb/tb_serial_adder.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/serial_adder.sv
// Bit-serial N-bit adder: LSB first, one bit per clock, registered carry, valid/ready on both sides.
// Optional SERIAL_ADDER_SUB_MODE_EN adds a 'sub' input that turns each bit into a full subtractor.
module serial_adder #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
`ifdef SERIAL_ADDER_SUB_MODE_EN
  input  logic             sub,
`endif
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             busy
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

  state_e           state_q, state_d;
  logic [WIDTH-1:0] a_sh_q, a_sh_d;
  logic [WIDTH-1:0] b_sh_q, b_sh_d;
  logic [WIDTH-1:0] sum_q, sum_d;
  logic             carry_q, carry_d;
  logic             cout_q, cout_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
`ifdef SERIAL_ADDER_SUB_MODE_EN
  logic             sub_q, sub_d;
`endif

  logic bit_a, bit_b, bit_s, bit_c;
  logic last_bit;

  // NOTE: non-blocking assignments here so every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // NOTE: shift registers are reset too, so an aborted transaction leaves no stale bits visible on sum.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_sh_q  <= '0;
      b_sh_q  <= '0;
      sum_q   <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      cnt_q   <= '0;
`ifdef SERIAL_ADDER_SUB_MODE_EN
      sub_q   <= 1'b0;
`endif
    end else begin
      a_sh_q  <= a_sh_d;
      b_sh_q  <= b_sh_d;
      sum_q   <= sum_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      cnt_q   <= cnt_d;
`ifdef SERIAL_ADDER_SUB_MODE_EN
      sub_q   <= sub_d;
`endif
    end
  end

  assign last_bit = (cnt_q == CNT_LAST);

  // One-bit cell: full adder, or full subtractor when sub mode was captured.
  always_comb begin
    bit_a = a_sh_q[0];
    bit_b = b_sh_q[0];
    bit_s = bit_a ^ bit_b ^ carry_q;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    if (sub_q) begin
      bit_c = (~bit_a & bit_b) | (~bit_a & carry_q) | (bit_b & carry_q);
    end else begin
      bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
    end
`else
    bit_c = (bit_a & bit_b) | (bit_a & carry_q) | (bit_b & carry_q);
`endif
  end

  // NOTE: every combinational output gets a default first so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (in_valid)  state_d = RUN;
      RUN:     if (last_bit)  state_d = DONE;
      DONE:    if (out_ready) state_d = IDLE;
      default:                state_d = IDLE;
    endcase
  end

  always_comb begin
    a_sh_d  = a_sh_q;
    b_sh_d  = b_sh_q;
    sum_d   = sum_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    cnt_d   = cnt_q;
`ifdef SERIAL_ADDER_SUB_MODE_EN
    sub_d   = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (in_valid) begin
          a_sh_d  = a;
          b_sh_d  = b;
          carry_d = cin;
          cnt_d   = '0;
`ifdef SERIAL_ADDER_SUB_MODE_EN
          sub_d   = sub;
`endif
        end
      end
      RUN: begin
        a_sh_d  = a_sh_q >> 1;
        b_sh_d  = b_sh_q >> 1;
        sum_d   = {bit_s, sum_q[WIDTH-1:1]};
        carry_d = bit_c;
        cnt_d   = cnt_q + 1'b1;
        if (last_bit) cout_d = bit_c;
      end
      default: ;
    endcase
  end

  // Handshake outputs are pure state decodes; no input reaches an output combinationally.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    busy      = (state_q == RUN) || (state_q == DONE);
    sum       = sum_q;
    cout      = cout_q;
  end

endmodule

// File: tb/tb_serial_adder.sv
// Randomized self-checking bench for serial_adder against an arithmetic reference model.
module tb_serial_adder;

  localparam int W = 8;
`ifdef SERIAL_ADDER_SUB_MODE_EN
  localparam bit SUB_ON = 1'b1;
`else
  localparam bit SUB_ON = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         in_valid;
  logic         in_ready;
  logic [W-1:0] a, b;
  logic         cin;
  logic         sub;
  logic         out_valid;
  logic         out_ready;
  logic [W-1:0] sum;
  logic         cout;
  logic         busy;

  int n_cmp = 0;
  int n_bad = 0;

  serial_adder #(.WIDTH(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .b         (b),
    .cin       (cin),
`ifdef SERIAL_ADDER_SUB_MODE_EN
    .sub       (sub),
`endif
    .out_valid (out_valid),
    .out_ready (out_ready),
    .sum       (sum),
    .cout      (cout),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Reference: plain integer arithmetic on the whole operands.
  task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb, input logic mc,
                       input logic ms, output logic [W-1:0] es, output logic ec);
    longint av, bv, r;
    av = longint'(ma);
    bv = longint'(mb);
    if (ms && SUB_ON) begin
      r  = av - bv - longint'(mc);
      es = W'(r);
      ec = (av < bv + longint'(mc));
    end else begin
      r  = av + bv + longint'(mc);
      es = W'(r);
      ec = r[W];
    end
  endtask

  task automatic do_txn(input logic [W-1:0] ta, input logic [W-1:0] tb2, input logic tc,
                        input logic ts, input int stall);
    logic [W-1:0] es;
    logic         ec;
    int           edges;
    bit           got;
    model(ta, tb2, tc, ts, es, ec);
    @(negedge clk);
    check("in_ready_idle", in_ready, 1);
    a = ta; b = tb2; cin = tc; sub = ts; in_valid = 1'b1;
    out_ready = (stall == 0);
    @(posedge clk);
    edges = 0;
    got   = 0;
    while (!got && edges < W + 4) begin
      @(negedge clk);
      if (out_valid) begin
        got = 1;
      end else begin
        in_valid = 1'($urandom);
        a = W'($urandom); b = W'($urandom); cin = 1'($urandom); sub = 1'($urandom);
        @(posedge clk);
        edges++;
      end
    end
    in_valid = 1'b0;
    if (!got) begin
      check("out_valid_timeout", 0, 1);
      return;
    end
    check("latency", edges, W);
    check("sum", sum, es);
    check("cout", cout, ec);
    check("busy_done", busy, 1);
    check("in_ready_done", in_ready, 0);
    for (int i = 0; i < stall; i++) begin
      in_valid = 1'b1;
      a = W'($urandom); b = W'($urandom); cin = 1'($urandom);
      out_ready = 1'b0;
      @(posedge clk);
      @(negedge clk);
      check("bp_valid", out_valid, 1);
      check("bp_sum", sum, es);
      check("bp_cout", cout, ec);
      check("bp_in_ready", in_ready, 0);
    end
    in_valid  = 1'b0;
    out_ready = 1'b1;
    check("in_ready_handshake_cycle", in_ready, 0);
    @(posedge clk);
    @(negedge clk);
    out_ready = 1'b0;
    check("valid_after_hs", out_valid, 0);
    check("in_ready_after_hs", in_ready, 1);
    check("busy_after_hs", busy, 0);
    check("sum_held_after_hs", sum, es);
    check("cout_held_after_hs", cout, ec);
  endtask

  task automatic reset_checks(input string tag);
    check({tag, "_in_ready"}, in_ready, 1);
    check({tag, "_out_valid"}, out_valid, 0);
    check({tag, "_busy"}, busy, 0);
    check({tag, "_sum"}, sum, 0);
    check({tag, "_cout"}, cout, 0);
  endtask

  initial begin
    rst = 1'b1; in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0; out_ready = 1'b0;
    #1;
    reset_checks("reset");
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    reset_checks("post_reset");

    do_txn(8'h35, 8'h4A, 1'b0, 1'b0, 0);
    do_txn(8'hFF, 8'h01, 1'b0, 1'b0, 0);
    do_txn(8'hFF, 8'hFF, 1'b1, 1'b0, 0);
    do_txn(8'hA5, 8'h5B, 1'b1, 1'b0, 5);
    do_txn(8'h0C, 8'h07, 1'b0, 1'b0, 0);

    // Abort a transaction after three RUN cycles.
    @(negedge clk);
    a = 8'h12; b = 8'h34; cin = 1'b0; sub = 1'b0; in_valid = 1'b1;
    @(posedge clk);
    @(negedge clk);
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("mid_run_sum_nonzero", (sum != 0), 1);
    @(negedge clk);
    rst = 1'b1;
    #1;
    reset_checks("mid_reset");
    repeat (2) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    do_txn(8'h10, 8'h20, 1'b0, 1'b0, 0);

    if (SUB_ON) begin
      do_txn(8'h10, 8'h20, 1'b0, 1'b1, 0);
      do_txn(8'h20, 8'h10, 1'b1, 1'b1, 2);
      do_txn(8'h01, 8'h01, 1'b0, 1'b0, 0);
      do_txn(8'h00, 8'h00, 1'b1, 1'b1, 0);
    end

    for (int i = 0; i < 40; i++) begin
      do_txn(W'($urandom), W'($urandom), 1'($urandom), 1'($urandom), int'($urandom_range(0, 3)));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
